// File: rtl/pmp_check_sequencer.sv
// pmp_check_sequencer
// Time-shares one combinational PMP checker among NR_REQ requesters. A
// round-robin arbiter picks one request, the sequencer checks its first byte
// and, when the access straddles a PMP granule, also its last byte. The
// allow/deny verdict goes back to the winning requester over a valid/ready
// handshake. Only one request is in flight at a time.
module pmp_check_sequencer #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned NR_REQ     = 2,
  parameter int unsigned GRAIN_LOG2 = 2,
  parameter type         access_t   = logic [2:0],
  parameter type         priv_t     = logic [1:0]
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic    [NR_REQ-1:0]           req_valid_i,
  output logic    [NR_REQ-1:0]           req_ready_o,
  input  logic    [NR_REQ-1:0][PLEN-1:0] req_addr_i,
  input  logic    [NR_REQ-1:0][1:0]      req_size_i,
  input  access_t [NR_REQ-1:0]           req_access_i,
  input  priv_t   [NR_REQ-1:0]           req_priv_i,
  output logic    [NR_REQ-1:0]           rsp_valid_o,
  input  logic    [NR_REQ-1:0]           rsp_ready_i,
  output logic                           rsp_allow_o,
  output logic    [PLEN-1:0]             pmp_addr_o,
  output access_t                        pmp_access_type_o,
  output priv_t                          pmp_priv_lvl_o,
  input  logic                           pmp_allow_i
);

  localparam int unsigned ID_W       = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam priv_t       PRIV_LVL_U = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK_LO = 2'd1,
    CHECK_HI = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Sequencer state and latched request fields.
  state_e              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     id_r;
  logic [PLEN-1:0]     addr_r;
  logic [1:0]          size_r;
  access_t             access_r;
  priv_t               priv_r;
  logic [NR_REQ-1:0]   rsp_valid_r;
  logic                rsp_allow_r;

  // Combinational helpers.
  logic                grant_valid_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [NR_REQ-1:0]   req_ready_s;
  logic [PLEN:0]       len_s;
  logic [PLEN:0]       end_s;
  logic                overflow_s;
  logic                span_s;
  logic [PLEN-1:0]     pmp_addr_s;
  logic [NR_REQ-1:0]   id_onehot_s;
  logic                rsp_taken_s;

  // Round-robin grant: first valid requester after the pointer, with wrap.
  always_comb begin
    int unsigned     cand;
    logic [ID_W-1:0] idx;
    logic            hit;
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    cand          = 32'd0;
    idx           = '0;
    hit           = 1'b0;
    for (int unsigned i = 1; i <= NR_REQ; i++) begin
      cand          = (32'(ptr_r) + i) % NR_REQ;
      idx           = cand[ID_W-1:0];
      hit           = !grant_valid_s && req_valid_i[idx];
      grant_id_s    = hit ? idx : grant_id_s;
      grant_valid_s = grant_valid_s | hit;
    end
  end

  // Accept strobe: only offered while idle and not being flushed.
  always_comb begin
    req_ready_s = '0;
    if ((state_r == IDLE) && !flush_i && grant_valid_s) begin
      req_ready_s = NR_REQ'(1'b1) << grant_id_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Last-byte address, carry out of the address space, and granule crossing.
  always_comb begin
    len_s      = (PLEN+1)'(1'b1) << size_r;
    end_s      = {1'b0, addr_r} + len_s - (PLEN+1)'(1'b1);
    overflow_s = end_s[PLEN];
    span_s     = (end_s[PLEN-1:GRAIN_LOG2] != addr_r[PLEN-1:GRAIN_LOG2]);
  end

  // Checker address: last byte during the second check, otherwise first byte.
  always_comb begin
    pmp_addr_s = addr_r;
    if (state_r == CHECK_HI) begin
      pmp_addr_s = end_s[PLEN-1:0];
    end else begin
      pmp_addr_s = addr_r;
    end
  end

  // Response routing and the owner's consume strobe; other ready bits are ignored.
  always_comb begin
    id_onehot_s = NR_REQ'(1'b1) << id_r;
    rsp_taken_s = rsp_ready_i[id_r];
  end

  // Main sequencer: accept, first-byte check, optional last-byte check, respond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      ptr_r       <= ID_W'(NR_REQ - 1);
      id_r        <= '0;
      addr_r      <= '0;
      size_r      <= 2'd0;
      access_r    <= '0;
      priv_r      <= PRIV_LVL_U;
      rsp_valid_r <= '0;
      rsp_allow_r <= 1'b0;
    end else if (flush_i) begin
      // Abort whatever is in flight; the pointer keeps its value.
      state_r     <= IDLE;
      rsp_valid_r <= '0;
      rsp_allow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            addr_r   <= req_addr_i[grant_id_s];
            size_r   <= req_size_i[grant_id_s];
            access_r <= req_access_i[grant_id_s];
            priv_r   <= req_priv_i[grant_id_s];
            id_r     <= grant_id_s;
            ptr_r    <= grant_id_s;
            state_r  <= CHECK_LO;
          end else begin
            state_r  <= IDLE;
          end
        end
        CHECK_LO: begin
          if (overflow_s || !pmp_allow_i) begin
            // Wrapping past the top of memory or a denied first byte fails outright.
            rsp_valid_r <= id_onehot_s;
            rsp_allow_r <= 1'b0;
            state_r     <= RESP;
          end else if (span_s) begin
            state_r     <= CHECK_HI;
          end else begin
            rsp_valid_r <= id_onehot_s;
            rsp_allow_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        CHECK_HI: begin
          rsp_valid_r <= id_onehot_s;
          rsp_allow_r <= pmp_allow_i;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_taken_s) begin
            rsp_valid_r <= '0;
            rsp_allow_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          rsp_allow_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o       = req_ready_s;
  assign rsp_valid_o       = rsp_valid_r;
  assign rsp_allow_o       = rsp_allow_r;
  assign pmp_addr_o        = pmp_addr_s;
  assign pmp_access_type_o = access_r;
  assign pmp_priv_lvl_o    = priv_r;

endmodule

// File: tb/tb_pmp_check_sequencer.sv
// Testbench for pmp_check_sequencer: directed scenarios plus randomized
// transactions checked against a behavioural model of arbitration and
// PMP span/overflow rules. The PMP checker itself is an address policy here.
module tb_pmp_check_sequencer;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][33:0] req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0][2:0]  req_access;
  logic [1:0][1:0]  req_priv;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic             rsp_allow;
  logic [33:0]      pmp_addr;
  logic [2:0]       pmp_access;
  logic [1:0]       pmp_priv;
  logic             pmp_allow;

  int               pol_mode;
  logic [33:0]      deny_addr;
  int               pass_cnt;
  int               total_cnt;

  pmp_check_sequencer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_size_i        (req_size),
    .req_access_i      (req_access),
    .req_priv_i        (req_priv),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_allow_o       (rsp_allow),
    .pmp_addr_o        (pmp_addr),
    .pmp_access_type_o (pmp_access),
    .pmp_priv_lvl_o    (pmp_priv),
    .pmp_allow_i       (pmp_allow)
  );

  // PMP checker stand-in: 0 allow all, 1 deny one byte address, 2 deny every third granule.
  function automatic logic pol_fn(input logic [33:0] a, input int mode, input logic [33:0] da);
    if (mode == 0) return 1'b1;
    else if (mode == 1) return (a != da);
    else return (((a >> 2) % 34'd3) != 34'd0);
  endfunction

  assign pmp_allow = pol_fn(pmp_addr, pol_mode, deny_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference verdict straight from the access rules.
  function automatic logic model_allow(input logic [33:0] a, input logic [1:0] sz);
    longint unsigned last;
    last = 64'(a) + (64'd1 << sz) - 64'd1;
    if (last >= (64'd1 << 34)) return 1'b0;
    if (!pol_fn(a, pol_mode, deny_addr)) return 1'b0;
    if ((last >> 2) != (64'(a) >> 2)) return pol_fn(last[33:0], pol_mode, deny_addr);
    return 1'b1;
  endfunction

  // Reference latency: a second lookup only happens after a passing first byte of a spanning access.
  function automatic int model_latency(input logic [33:0] a, input logic [1:0] sz);
    longint unsigned last;
    last = 64'(a) + (64'd1 << sz) - 64'd1;
    if (last >= (64'd1 << 34)) return 2;
    if (!pol_fn(a, pol_mode, deny_addr)) return 2;
    if ((last >> 2) != (64'(a) >> 2)) return 3;
    return 2;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic release_rsp(input logic [1:0] oh);
    rsp_ready = oh;
    next_cycle();
    rsp_ready = 2'b00;
  endtask

  task automatic issue_req0(input logic [33:0] a, input logic [1:0] sz);
    req_addr[0]   = a;
    req_size[0]   = sz;
    req_access[0] = 3'b001;
    req_priv[0]   = 2'b01;
    req_valid     = 2'b01;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_allow !== 1'b0)
      $display("FAIL reset_hs: ready=%b rsp_valid=%b allow=%b, required 00/00/0", req_ready, rsp_valid, rsp_allow);
    else pass_cnt++;
    total_cnt++;
    if (pmp_addr !== 34'h0 || pmp_access !== 3'b000 || pmp_priv !== 2'b00)
      $display("FAIL reset_pmp: addr=%h access=%b priv=%b, required 0/000/00", pmp_addr, pmp_access, pmp_priv);
    else pass_cnt++;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    pol_mode = 0;
    issue_req0(34'h1000, 2'd2);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL single_ready: got %b, required 01", req_ready);
    else pass_cnt++;
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++;
    if (pmp_addr !== 34'h1000 || pmp_access !== 3'b001 || pmp_priv !== 2'b01 || rsp_valid !== 2'b00)
      $display("FAIL single_lo: addr=%h acc=%b priv=%b rsp_valid=%b, required 1000/001/01/00",
               pmp_addr, pmp_access, pmp_priv, rsp_valid);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1)
      $display("FAIL single_rsp: rsp_valid=%b allow=%b, required 01/1", rsp_valid, rsp_allow);
    else pass_cnt++;
    release_rsp(2'b01);
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b00) $display("FAIL single_done: rsp_valid=%b, required 00", rsp_valid);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_span();
    pol_mode  = 1;
    deny_addr = 34'h2001;
    issue_req0(34'h1FFE, 2'd2);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++;
    if (pmp_addr !== 34'h1FFE) $display("FAIL span_lo_addr: got %h, required 1FFE", pmp_addr);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (pmp_addr !== 34'h2001 || rsp_valid !== 2'b00)
      $display("FAIL span_hi_addr: addr=%h rsp_valid=%b, required 2001/00", pmp_addr, rsp_valid);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b0)
      $display("FAIL span_rsp: rsp_valid=%b allow=%b, required 01/0", rsp_valid, rsp_allow);
    else pass_cnt++;
    release_rsp(2'b01);
  endtask

  task automatic test_early_deny();
    pol_mode  = 1;
    deny_addr = 34'h1FFE;
    issue_req0(34'h1FFE, 2'd2);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b0)
      $display("FAIL early_deny: rsp_valid=%b allow=%b, required 01/0 at cycle 2", rsp_valid, rsp_allow);
    else pass_cnt++;
    release_rsp(2'b01);
  endtask

  task automatic test_wrap();
    pol_mode = 0;
    issue_req0(34'h3_FFFF_FFFC, 2'd3);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b0)
      $display("FAIL wrap: rsp_valid=%b allow=%b, required 01/0", rsp_valid, rsp_allow);
    else pass_cnt++;
    release_rsp(2'b01);
  endtask

  task automatic test_round_robin();
    logic [1:0] oh;
    bit         got;
    pulse_reset();
    pol_mode      = 0;
    req_addr[0]   = 34'h100;
    req_addr[1]   = 34'h200;
    req_size      = '0;
    req_access    = '0;
    req_priv      = '0;
    rsp_ready     = 2'b11;
    req_valid     = 2'b11;
    for (int n = 0; n < 4; n++) begin
      oh = 2'b01 << (n % 2);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (req_ready !== 2'b00) got = 1'b1;
        else next_cycle();
      end
      total_cnt++;
      if (req_ready !== oh) $display("FAIL rr_grant%0d: ready=%b, required %b", n, req_ready, oh);
      else pass_cnt++;
      next_cycle();
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (rsp_valid !== 2'b00) got = 1'b1;
        else next_cycle();
      end
      total_cnt++;
      if (rsp_valid !== oh || rsp_allow !== 1'b1)
        $display("FAIL rr_rsp%0d: rsp_valid=%b allow=%b, required %b/1", n, rsp_valid, rsp_allow, oh);
      else pass_cnt++;
      if (n == 3) req_valid = 2'b00;
      next_cycle();
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    bit bad;
    pol_mode = 0;
    issue_req0(34'h40, 2'd0);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1) bad = 1'b1;
      rsp_ready = 2'b10;
      next_cycle();
    end
    total_cnt++;
    if (bad !== 1'b0 || rsp_valid !== 2'b01 || rsp_allow !== 1'b1)
      $display("FAIL backpressure_hold: rsp_valid=%b allow=%b unstable=%0d, required 01/1/0", rsp_valid, rsp_allow, bad);
    else pass_cnt++;
    release_rsp(2'b01);
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b00) $display("FAIL backpressure_release: rsp_valid=%b, required 00", rsp_valid);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_flush();
    bit seen;
    pol_mode = 0;
    issue_req0(34'h80, 2'd0);
    next_cycle();
    req_valid = 2'b00;
    flush     = 1'b1;
    next_cycle();
    flush = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
      next_cycle();
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_drop: response seen=%0d, required 0", seen);
    else pass_cnt++;
    flush = 1'b1;
    issue_req0(34'h84, 2'd1);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL flush_block: ready=%b, required 00", req_ready);
    else pass_cnt++;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL flush_resume_ready: ready=%b, required 01", req_ready);
    else pass_cnt++;
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01 || rsp_allow !== 1'b1)
      $display("FAIL flush_resume_rsp: rsp_valid=%b allow=%b, required 01/1", rsp_valid, rsp_allow);
    else pass_cnt++;
    release_rsp(2'b01);
  endtask

  task automatic test_reset_in_resp();
    pol_mode = 0;
    issue_req0(34'h500, 2'd0);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 2'b01) $display("FAIL rst_resp_pre: rsp_valid=%b, required 01", rsp_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== 2'b00 || rsp_allow !== 1'b0)
      $display("FAIL rst_resp_drop: rsp_valid=%b allow=%b, required 00/0", rsp_valid, rsp_allow);
    else pass_cnt++;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_random();
    int          rr_ptr;
    int          g;
    int          lat;
    int          exp_lat;
    int          stall;
    logic        exp_allow;
    logic [1:0]  oh;
    bit          got;
    bit          bad;
    logic [33:0] ga;
    logic [1:0]  gs;
    pulse_reset();
    rr_ptr = 1;
    for (int t = 0; t < 200; t++) begin
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 3))
          0:       req_addr[r] = 34'h3_FFFF_FFF8 + 34'($urandom_range(0, 7));
          1:       req_addr[r] = {2'b00, $urandom()};
          2:       req_addr[r] = {2'($urandom_range(0, 3)), $urandom()};
          default: req_addr[r] = 34'($urandom_range(0, 255));
        endcase
        req_size[r]   = 2'($urandom_range(0, 3));
        req_access[r] = 3'($urandom_range(0, 7));
        req_priv[r]   = 2'($urandom_range(0, 3));
      end
      req_valid = 2'($urandom_range(1, 3));
      g = -1;
      for (int i = 1; i <= 2; i++)
        if (g < 0 && req_valid[(rr_ptr + i) % 2]) g = (rr_ptr + i) % 2;
      oh = 2'b01 << g;
      ga = req_addr[g];
      gs = req_size[g];
      pol_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) deny_addr = ga;
      else deny_addr = ga + ((34'd1 << gs) - 34'd1);
      exp_allow = model_allow(ga, gs);
      exp_lat   = model_latency(ga, gs);
      @(negedge clk);
      total_cnt++;
      if (req_ready !== oh) $display("FAIL rnd_grant t=%0d: ready=%b, required %b", t, req_ready, oh);
      else pass_cnt++;
      next_cycle();
      req_valid = 2'b00;
      lat = 1;
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        if (lat == 1) begin
          total_cnt++;
          if (pmp_addr !== ga || pmp_access !== req_access[g] || pmp_priv !== req_priv[g])
            $display("FAIL rnd_pmp t=%0d: addr=%h acc=%b priv=%b, required %h/%b/%b",
                     t, pmp_addr, pmp_access, pmp_priv, ga, req_access[g], req_priv[g]);
          else pass_cnt++;
        end
        if (rsp_valid !== 2'b00) got = 1'b1;
        else begin
          next_cycle();
          lat++;
        end
      end
      total_cnt++;
      if (!got || lat != exp_lat)
        $display("FAIL rnd_latency t=%0d: got=%0d latency=%0d, required %0d", t, got, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== oh || rsp_allow !== exp_allow)
        $display("FAIL rnd_rsp t=%0d: rsp_valid=%b allow=%b, required %b/%b", t, rsp_valid, rsp_allow, oh, exp_allow);
      else pass_cnt++;
      stall = int'($urandom_range(0, 3));
      bad   = 1'b0;
      for (int s = 0; s < stall; s++) begin
        rsp_ready = ~oh;
        next_cycle();
        @(negedge clk);
        if (rsp_valid !== oh || rsp_allow !== exp_allow) bad = 1'b1;
      end
      total_cnt++;
      if (bad !== 1'b0) $display("FAIL rnd_hold t=%0d: response changed while stalled", t);
      else pass_cnt++;
      release_rsp(oh | 2'($urandom_range(0, 3)));
      rr_ptr = g;
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst_n      = 1'b1;
    flush      = 1'b0;
    req_valid  = 2'b00;
    req_addr   = '0;
    req_size   = '0;
    req_access = '0;
    req_priv   = '0;
    rsp_ready  = 2'b00;
    pol_mode   = 0;
    deny_addr  = 34'h0;
    test_reset();
    test_single();
    test_span();
    test_early_deny();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_in_resp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
